// File: rtl/event_logger_pkg.sv
// Shared definitions for the event logger.
// Record field layout, FSM encoding, sequence width and a record packer.
package event_logger_pkg;

  localparam int REC_W   = 16;
  localparam int SEQ_W   = 6;

  localparam int INC_LSB = 12;
  localparam int INC_W   = 4;
  localparam int BB_LSB  = 8;
  localparam int BB_W    = 4;
  localparam int AB_BIT  = 7;
  localparam int DE_BIT  = 6;
  localparam int SEQ_LSB = 0;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_STOPPED = 2'd2;

  function automatic logic [REC_W-1:0] make_rec(
    input logic [INC_W-1:0] inc,
    input logic [BB_W-1:0]  bb,
    input logic             ab,
    input logic             de,
    input logic [SEQ_W-1:0] seq
  );
    logic [REC_W-1:0] r;
    r = '0;
    r[INC_LSB +: INC_W] = inc;
    r[BB_LSB +: BB_W]   = bb;
    r[AB_BIT]           = ab;
    r[DE_BIT]           = de;
    r[SEQ_LSB +: SEQ_W] = seq;
    return r;
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// Synchronous FIFO with wrap-bit pointers and occupancy output.
// Ports: clk, rst, push/wdata, pop/rdata (0 when empty), full, empty, level.
module evt_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         do_pop;
  logic         do_push;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level = wr_q - rd_q;

  // A pop frees the slot a same-cycle push needs when full.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/event_logger.sv
// Coprocessor event logger: edge capture, arm/stop FSM, record FIFO.
// Ports: clk/rst, arm, bank/incident/done inputs, evt_* stream, ovf/drop_cnt/level/busy.
module event_logger
  import event_logger_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter bit STOP_ON_DONE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        A_bank,
  input  logic [3:0]  B_bank,
  input  logic [3:0]  incident,
  input  logic        done,
  output logic        evt_valid,
  output logic [15:0] evt_data,
  input  logic        evt_ready,
  output logic        ovf,
  input  logic        clr_ovf,
  output logic [7:0]  drop_cnt,
  output logic [4:0]  level,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]       state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [3:0]       prev_inc_q;
  logic             prev_done_q;
  logic             ovf_q, ovf_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic             inc_new;
  logic             done_edge;
  logic             cap;
  logic             pop;
  logic             drop;
  logic [REC_W-1:0] rec;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW:0]      fifo_level;

  always_comb begin
    inc_new    = (incident != 4'd0) && (incident != prev_inc_q);
    done_edge  = done && !prev_done_q;
    cap        = (state_q == ST_ARMED) && (inc_new || done_edge);
    rec        = make_rec(incident, B_bank, A_bank, done_edge, seq_q);
    pop        = evt_valid && evt_ready;
    drop       = cap && fifo_full && !pop;

    state_d    = state_q;
    seq_d      = seq_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;

    if (cap) seq_d = seq_q + SEQ_W'(1);

    unique case (state_q)
      ST_ARMED: begin
        if (STOP_ON_DONE && cap && done_edge) state_d = ST_STOPPED;
      end
      default: begin
        if (arm) begin
          state_d = ST_ARMED;
          seq_d   = '0;
        end
      end
    endcase

    // Clearing wins over a coincident drop.
    if (clr_ovf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      seq_q       <= '0;
      prev_inc_q  <= '0;
      prev_done_q <= 1'b0;
      ovf_q       <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      prev_inc_q  <= incident;
      prev_done_q <= done;
      ovf_q       <= ovf_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  evt_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cap),
    .wdata (rec),
    .pop   (pop),
    .rdata (evt_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign evt_valid = !fifo_empty;
  assign level     = 5'(fifo_level);
  assign ovf       = ovf_q;
  assign drop_cnt  = drop_cnt_q;
  assign busy      = (state_q == ST_ARMED);

endmodule

// File: tb/tb_event_logger.sv
// Randomized bench for event_logger against a queue-based model.
// Directed scenarios pin the model with literal expectations.
module tb_event_logger;

  localparam int DEPTH = 8;
  localparam bit STOP  = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic        a_bank;
  logic [3:0]  b_bank;
  logic [3:0]  incident;
  logic        done;
  logic        evt_valid;
  logic [15:0] evt_data;
  logic        evt_ready;
  logic        ovf;
  logic        clr_ovf;
  logic [7:0]  drop_cnt;
  logic [4:0]  level;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  event_logger #(
    .DEPTH        (DEPTH),
    .STOP_ON_DONE (STOP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arm       (arm),
    .A_bank    (a_bank),
    .B_bank    (b_bank),
    .incident  (incident),
    .done      (done),
    .evt_valid (evt_valid),
    .evt_data  (evt_data),
    .evt_ready (evt_ready),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf),
    .drop_cnt  (drop_cnt),
    .level     (level),
    .busy      (busy)
  );

  // Model: 0 idle, 1 armed, 2 stopped.
  logic [15:0] mq[$];
  int          m_st;
  int          m_seq;
  int          m_drops;
  bit          m_ovf;
  logic [3:0]  m_pinc;
  bit          m_pdone;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_step();
    bit          pop;
    bit          gen;
    bit          dedge;
    bit          dropped;
    logic [15:0] r;
    if (rst) begin
      mq.delete();
      m_st = 0; m_seq = 0; m_drops = 0;
      m_ovf = 0; m_pinc = 0; m_pdone = 0;
      return;
    end
    pop   = (mq.size() > 0) && evt_ready;
    dedge = done && !m_pdone;
    gen   = (m_st == 1) &&
            ((incident != 0 && incident != m_pinc) || dedge);
    r = {incident, b_bank, a_bank, dedge, 6'(m_seq)};
    dropped = 0;
    if (pop) void'(mq.pop_front());
    if (gen) begin
      if (mq.size() < DEPTH) mq.push_back(r);
      else dropped = 1;
      m_seq = (m_seq + 1) % 64;
    end
    if (clr_ovf) begin
      m_ovf = 0; m_drops = 0;
    end else if (dropped) begin
      m_ovf = 1;
      if (m_drops < 255) m_drops++;
    end
    if (m_st != 1 && arm) begin
      m_st = 1; m_seq = 0;
    end else if (gen && dedge && STOP) begin
      m_st = 2;
    end
    m_pinc  = incident;
    m_pdone = done;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #2;
      chk("valid", 32'(evt_valid), 32'(mq.size() != 0));
      chk("data", 32'(evt_data),
          (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
      chk("level", 32'(level), 32'(mq.size()));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
      chk("busy", 32'(busy), 32'(m_st == 1));
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_rst();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  int rdy_pct;

  initial begin
    rst = 1'b1; arm = 0; a_bank = 1; b_bank = 4'h2;
    incident = 0; done = 0; evt_ready = 0; clr_ovf = 0;
    tick(2);
    rst = 1'b0;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // First capture after arm
    do_arm();
    chk("arm_busy", 32'(busy), 32'd1);
    incident = 4'd3; tick();
    chk("first_valid", 32'(evt_valid), 32'd1);
    chk("first_data", 32'(evt_data), 32'h3280);

    // Held incident gives one record, re-edge gives second
    incident = 0; do_rst(); do_arm();
    incident = 4'd5; tick(10);
    chk("hold_level", 32'(level), 32'd1);
    chk("hold_data", 32'(evt_data), 32'h5280);
    incident = 0; tick(); incident = 4'd5; tick();
    chk("reedge_level", 32'(level), 32'd2);
    evt_ready = 1; tick(); evt_ready = 0;
    chk("reedge_data", 32'(evt_data), 32'h5281);

    // Overflow
    incident = 0; do_rst(); do_arm();
    for (int i = 1; i <= 10; i++) begin
      incident = 4'(i); tick();
    end
    chk("ovf_level", 32'(level), 32'd8);
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("ovf_drops", 32'(drop_cnt), 32'd2);
    clr_ovf = 1; tick(); clr_ovf = 0;
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_drops", 32'(drop_cnt), 32'd0);

    // Full with simultaneous push and pop
    evt_ready = 1; incident = 4'd11; tick(); evt_ready = 0;
    chk("pp_level", 32'(level), 32'd8);
    chk("pp_drops", 32'(drop_cnt), 32'd0);
    chk("pp_head", 32'(evt_data), 32'h2281);

    // Done edge stops logging
    incident = 0; do_rst(); do_arm();
    evt_ready = 1; done = 1; tick();
    chk("done_valid", 32'(evt_valid), 32'd1);
    chk("done_data", 32'(evt_data), 32'h02C0);
    chk("done_busy", 32'(busy), 32'd0);
    incident = 4'd7; tick(); incident = 4'd9; tick();
    chk("stop_level", 32'(level), 32'd0);
    do_arm();
    chk("rearm_busy", 32'(busy), 32'd1);
    evt_ready = 0;

    // Reset mid-burst
    for (int i = 1; i <= 4; i++) begin
      incident = 4'(i); tick();
    end
    chk("burst_level", 32'(level), 32'd4);
    rst = 1; tick(); rst = 0;
    chk("mrst_valid", 32'(evt_valid), 32'd0);
    chk("mrst_level", 32'(level), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_data", 32'(evt_data), 32'd0);

    // Random phase
    rdy_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) rdy_pct = $urandom_range(5, 90);
      rst       = ($urandom_range(0, 299) == 0);
      arm       = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 2) == 0)
        incident = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) done = ~done;
      a_bank    = 1'($urandom);
      b_bank    = 4'($urandom);
      evt_ready = ($urandom_range(0, 99) < rdy_pct);
      clr_ovf   = ($urandom_range(0, 63) == 0);
      tick();
    end

    rst = 0; arm = 0; clr_ovf = 0; evt_ready = 0;
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/event_logger.md
EVENT_LOGGER -- requirements
Module: event_logger

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter STOP_ON_DONE, default 1, stop logging after captured done edge.
REQ-003 SHALL have one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 arm  input  1  one-cycle pulse, start/restart logging.
REQ-007 A_bank  input  1  coprocessor A-bank select.
REQ-008 B_bank  input  4  coprocessor B-bank select.
REQ-009 incident  input  4  coprocessor incident code, 0 = none.
REQ-010 done  input  1  coprocessor completion level.
REQ-011 evt_valid  output  1  FIFO head record valid.
REQ-012 evt_data  output  16  FIFO head record.
REQ-013 evt_ready  input  1  consumer accepts head when high with evt_valid.
REQ-014 ovf  output  1  sticky overflow flag.
REQ-015 clr_ovf  input  1  clears ovf and drop_cnt.
REQ-016 drop_cnt  output  8  dropped-record count, saturating.
REQ-017 level  output  5  current FIFO occupancy.
REQ-018 busy  output  1  high while state is ARMED.

Function
REQ-019 States IDLE, ARMED, STOPPED; IDLE->ARMED and STOPPED->ARMED on arm; ARMED->STOPPED on captured done edge when STOP_ON_DONE=1; arm in ARMED ignored.
REQ-020 prev_incident/prev_done registers update every cycle regardless of state.
REQ-021 Capture condition (ARMED only): (incident!=0 and incident!=prev_incident) or (done and !prev_done).
REQ-022 Record: [15:12] incident, [11:8] B_bank, [7] A_bank, [6] done edge flag, [5:0] seq.
REQ-023 seq increments by 1 per generated record (accepted or dropped), wraps 63->0, reset to 0 on each accepted arm.
REQ-024 Record written at the edge sampling the condition; evt_valid high from the next cycle; latency 1 cycle input-to-valid.
REQ-025 Pop when evt_valid and evt_ready; evt_data is the oldest record, stable while evt_valid and !evt_ready.
REQ-026 Full FIFO with push and no pop: record dropped, ovf set, drop_cnt +1 saturating at 255.
REQ-027 Full FIFO with simultaneous push and pop: both occur, level unchanged, no drop.
REQ-028 Empty FIFO with push and evt_ready: no bypass; record appears next cycle.
REQ-029 clr_ovf coincident with a drop: clear wins, ovf=0, drop_cnt=0.
REQ-030 arm does not flush FIFO contents.
REQ-031 level = entries held, 0..DEPTH; pointers wrap modulo DEPTH with extra wrap bit.

Reset
REQ-032 rst at any cycle, including mid-burst, SHALL force: state IDLE, FIFO empty, evt_valid 0, evt_data 0, level 0, ovf 0, drop_cnt 0, busy 0, seq 0, prev_incident 0, prev_done 0.
REQ-033 Inputs sampled during rst SHALL NOT generate records.

Structure
REQ-034 Shared package SHALL hold record field positions/widths, state encoding, seq width.
REQ-035 FIFO SHALL be sub-module evt_fifo (DEPTH, 16-bit, push/pop/full/empty/level); capture and FSM in event_logger.

Verification
REQ-036 rst, arm, incident 0->3 with B_bank=4'b0010, A_bank=1 -> one cycle later evt_valid=1, evt_data=16'h32_80, seq 0.
REQ-037 incident held at 5 for 10 cycles -> exactly one record; then 5->0->5 -> second record, seq 1.
REQ-038 evt_ready=0, 10 distinct incidents, DEPTH=8 -> level 8, ovf=1, drop_cnt=2; clr_ovf -> both 0.
REQ-039 Full FIFO, evt_ready=1 and new incident same cycle -> level stays 8, drop_cnt unchanged.
REQ-040 done rising edge with STOP_ON_DONE=1 -> record bit6=1, busy falls next cycle, further incidents ignored until arm.
REQ-041 rst asserted with 4 entries queued -> next cycle evt_valid=0, level 0, state IDLE.
